// File: rtl/l_shl_seq_pkg.sv
// Shared constants for the sequential G.729 L_shl block: state codes,
// saturation bounds and the shift-count clip helper.
package l_shl_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHL  = 2'd1;
    localparam logic [1:0] ST_SHR  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32 = 32'h8000_0000;

    // One more left shift from outside this window would overflow Q31.
    localparam logic [31:0] SAT_HI = 32'h3FFF_FFFF;
    localparam logic [31:0] SAT_LO = 32'hC000_0000;

    localparam int SHIFT_LIMIT = 31;

    // Magnitude of the shift count, clipped to 31; widened first so -32768 cannot wrap.
    function automatic logic [4:0] clip_count(input logic [15:0] var2);
        logic signed [16:0] wide;
        logic signed [16:0] mag;
        wide = $signed({var2[15], var2});
        mag  = (wide > 17'sd0) ? wide : -wide;
        if (mag > 17'(SHIFT_LIMIT))
            return 5'(SHIFT_LIMIT);
        return mag[4:0];
    endfunction

endpackage

// File: rtl/l_shl_seq.sv
// Bit-serial G.729 L_shl: shifts a Q31 operand one bit per clock with
// saturation on left shifts and sign-filling right shifts.
//
// state   | meaning
// IDLE    | waiting for ready; accept loads operand and count
// SHL     | left shift one bit per edge, saturate early on overflow
// SHR     | arithmetic right shift one bit per edge
// DONE_ST | done high for this cycle; ready ignored
module l_shl_seq
    import l_shl_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] var1,
    input  logic [15:0] var2,
    input  logic        ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        done,
    output logic        busy
);

    logic [1:0]  state;
    logic [4:0]  count;
    logic [31:0] work;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= 5'd0;
            work     <= 32'd0;
            result   <= 32'd0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        work     <= var1;
                        overflow <= 1'b0;
                        count    <= clip_count(var2);
                        state    <= ($signed(var2) > 16'sd0) ? ST_SHL : ST_SHR;
                    end
                end
                ST_SHL: begin
                    if (count == 5'd0) begin
                        result <= work;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if ($signed(work) > $signed(SAT_HI)) begin
                        result   <= MAX_32;
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else if ($signed(work) < $signed(SAT_LO)) begin
                        result   <= MIN_32;
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        work  <= {work[30:0], 1'b0};
                        count <= count - 5'd1;
                    end
                end
                ST_SHR: begin
                    if (count == 5'd0) begin
                        result <= work;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        work  <= {work[31], work[31:1]};
                        count <= count - 5'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_l_shl_seq.sv
// Scoreboard bench for l_shl_seq: directed requests push expected result,
// overflow and latency; a done-driven monitor pops and compares.
`timescale 1ns/1ps
module tb_l_shl_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] var1;
    logic [15:0] var2;
    logic        ready;
    logic [31:0] result;
    logic        overflow;
    logic        done;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    l_shl_seq dut (
        .clk      (clk),
        .reset    (rst_n),
        .var1     (var1),
        .var2     (var2),
        .ready    (ready),
        .result   (result),
        .overflow (overflow),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: done high at cycle %0d, expected no pending request", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b, expected 0", busy);
        end
    endtask

    task automatic issue(input logic [31:0] v1, input logic [15:0] v2,
                         input logic [31:0] er, input logic eo, input int lat);
        wait_idle();
        var1  = v1;
        var2  = v2;
        ready = 1'b1;
        q.push_back('{er, eo, lat, cyc + 1});
        @(negedge clk);
        ready = 1'b0;
        var1  = ~v1;
        var2  = ~v2;
    endtask

    initial begin
        int c;
        int n;
        rst_n = 1'b0;
        ready = 1'b0;
        var1  = 32'hDEAD_BEEF;
        var2  = 16'h0005;
        #3;
        chk("rst_result", result, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(32'h0001_2345, 16'd4,      32'h0012_3450, 1'b0, 5);
        issue(32'h4000_0000, 16'd1,      32'h7FFF_FFFF, 1'b1, 1);
        issue(32'hC000_0001, 16'd3,      32'h8000_0000, 1'b1, 2);
        issue(32'h8000_0000, 16'h8000,   32'hFFFF_FFFF, 1'b0, 32);
        issue(32'h7FFF_FFFF, 16'hFFDD,   32'h0000_0000, 1'b0, 32);
        issue(32'h0000_0000, 16'd10,     32'h0000_0000, 1'b0, 11);
        issue(32'h0000_0000, 16'd100,    32'h0000_0000, 1'b0, 32);
        issue(32'hF000_0000, 16'hFFFC,   32'hFF00_0000, 1'b0, 5);
        issue(32'hFFFF_FFFF, 16'd5,      32'hFFFF_FFE0, 1'b0, 6);
        issue(32'h0000_0003, 16'd31,     32'h7FFF_FFFF, 1'b1, 30);
        issue(32'h1234_5678, 16'd0,      32'h1234_5678, 1'b0, 1);

        // ready held high: accepts on edges 1, 4, 7 relative to here.
        wait_idle();
        c     = cyc;
        var1  = 32'h1234_5678;
        var2  = 16'd0;
        ready = 1'b1;
        q.push_back('{32'h1234_5678, 1'b0, 1, c + 1});
        q.push_back('{32'h1234_5678, 1'b0, 1, c + 4});
        q.push_back('{32'h1234_5678, 1'b0, 1, c + 7});
        repeat (9) @(negedge clk);
        ready = 1'b0;

        // Reset in the middle of a 20-bit right shift.
        issue(32'h8765_4321, 16'hFFEC, 32'hFFFF_F876, 1'b0, 21);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        void'(q.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(32'h0000_0001, 16'd30, 32'h4000_0000, 1'b0, 31);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
